// File: rtl/rwt_tag_extract_if.sv
// Stream bundle for the tag extractor: escape-coded input beats in, decoded words with tag sideband out.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface rwt_tag_extract_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int TAG_TYPE_WIDTH = 7
);
  logic                      s_axi_valid;
  logic                      s_axi_ready;
  logic [DATA_WIDTH-1:0]     s_axi_data;
  logic                      s_axi_last;
  logic                      m_axi_valid;
  logic                      m_axi_ready;
  logic [DATA_WIDTH-1:0]     m_axi_data;
  logic                      m_axi_tag_valid;
  logic [TAG_TYPE_WIDTH-1:0] m_axi_tag_type;
  logic                      m_axi_last;

  modport slave (
    input  s_axi_valid, s_axi_data, s_axi_last, m_axi_ready,
    output s_axi_ready, m_axi_valid, m_axi_data, m_axi_tag_valid, m_axi_tag_type, m_axi_last
  );

  modport master (
    output s_axi_valid, s_axi_data, s_axi_last, m_axi_ready,
    input  s_axi_ready, m_axi_valid, m_axi_data, m_axi_tag_valid, m_axi_tag_type, m_axi_last
  );
endinterface

// File: rtl/rwt_tag_extract.sv
// Receive-side tag extractor: strips escape/header framing from the 64-bit user stream and
// restores plain samples plus in-band tag payloads through a single output register stage.
module rwt_tag_extract #(
  parameter int DATA_WIDTH     = 64,
  parameter int TAG_TYPE_WIDTH = 7,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     use_tags,
  input  logic [DATA_WIDTH-1:0]    tag_escape,
  rwt_tag_extract_if.slave         bus,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_ESC  = 2'd1,
    ST_TAG  = 2'd2
  } state_t;

  localparam logic [7:0] HDR_LITERAL = 8'h00;
  localparam logic [7:0] HDR_TAG     = 8'h01;

  state_t                    state_q;
  logic [TAG_TYPE_WIDTH-1:0] type_q;
  logic                      m_valid_q;
  logic [DATA_WIDTH-1:0]     m_data_q;
  logic                      m_tag_valid_q;
  logic [TAG_TYPE_WIDTH-1:0] m_tag_type_q;
  logic                      m_last_q;

  logic                      s_accept;
  logic                      is_escape;
  logic [7:0]                hdr_code;
  logic                      proto_err;

  assign bus.s_axi_ready     = ~m_valid_q | bus.m_axi_ready;
  assign bus.m_axi_valid     = m_valid_q;
  assign bus.m_axi_data      = m_data_q;
  assign bus.m_axi_tag_valid = m_tag_valid_q;
  assign bus.m_axi_tag_type  = m_tag_type_q;
  assign bus.m_axi_last      = m_last_q;

  assign s_accept  = bus.s_axi_valid & bus.s_axi_ready;
  assign is_escape = (bus.s_axi_data == tag_escape);
  assign hdr_code  = bus.s_axi_data[DATA_WIDTH-1 -: 8];

  // A frame may not end on an escape or tag header, and unknown header codes are dropped.
  always_comb begin
    proto_err = 1'b0;
    if (s_accept) begin
      unique case (state_q)
        ST_DATA: proto_err = use_tags & is_escape & bus.s_axi_last;
        ST_ESC:  proto_err = (hdr_code == HDR_TAG) ? bus.s_axi_last
                                                   : (hdr_code != HDR_LITERAL);
        default: proto_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_DATA;
      type_q        <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_tag_valid_q <= 1'b0;
      m_tag_type_q  <= '0;
      m_last_q      <= 1'b0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (m_valid_q && bus.m_axi_ready) begin
        m_valid_q <= 1'b0;
      end

      if (proto_err) begin
        err_pulse <= 1'b1;
        if (err_count != {ERR_CNT_WIDTH{1'b1}}) begin
          err_count <= err_count + 1'b1;
        end
      end

      // Escape and header beats are swallowed; only data, literal escapes and payloads load the output.
      if (s_accept) begin
        unique case (state_q)
          ST_DATA: begin
            if (use_tags && is_escape) begin
              state_q <= bus.s_axi_last ? ST_DATA : ST_ESC;
            end else begin
              m_valid_q     <= 1'b1;
              m_data_q      <= bus.s_axi_data;
              m_tag_valid_q <= 1'b0;
              m_tag_type_q  <= '0;
              m_last_q      <= bus.s_axi_last;
            end
          end
          ST_ESC: begin
            state_q <= ST_DATA;
            if (hdr_code == HDR_LITERAL) begin
              m_valid_q     <= 1'b1;
              m_data_q      <= tag_escape;
              m_tag_valid_q <= 1'b0;
              m_tag_type_q  <= '0;
              m_last_q      <= bus.s_axi_last;
            end else if ((hdr_code == HDR_TAG) && !bus.s_axi_last) begin
              type_q  <= bus.s_axi_data[TAG_TYPE_WIDTH-1:0];
              state_q <= ST_TAG;
            end
          end
          ST_TAG: begin
            state_q       <= ST_DATA;
            m_valid_q     <= 1'b1;
            m_data_q      <= bus.s_axi_data;
            m_tag_valid_q <= 1'b1;
            m_tag_type_q  <= type_q;
            m_last_q      <= bus.s_axi_last;
          end
          default: state_q <= ST_DATA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rwt_tag_extract.sv
// Directed and randomised-handshake bench for the tag extractor; output words are
// scoreboarded against hand-built expectations and, for the mixed stream, a small model.
module tb_rwt_tag_extract;

  logic        clk;
  logic        rst;
  logic        use_tags;
  logic [63:0] tag_escape;
  logic        err_pulse;
  logic [15:0] err_count;

  rwt_tag_extract_if bus ();

  rwt_tag_extract dut (
    .clk        (clk),
    .rst        (rst),
    .use_tags   (use_tags),
    .tag_escape (tag_escape),
    .bus        (bus),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic        rdy_rand  = 1'b0;
  logic        rdy_fixed = 1'b1;

  logic [72:0] exp_q[$];
  logic [72:0] got_q[$];
  int          got_base = 0;
  int          err_seen = 0;
  int          err_base = 0;

  int          m_state = 0;
  logic [6:0]  m_type  = '0;
  int          m_errs  = 0;

  localparam logic [63:0] ESC_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] ESC_R = 64'hE5C0_5A5A_0F0F_00E5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    bus.m_axi_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Handshakes and error pulses are sampled just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (bus.m_axi_valid === 1'b1 && bus.m_axi_ready === 1'b1)
        got_q.push_back({bus.m_axi_data, bus.m_axi_tag_valid, bus.m_axi_tag_type, bus.m_axi_last});
      if (err_pulse === 1'b1)
        err_seen++;
    end
  end

  initial begin
    #1_200_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [72:0] obs, input logic [72:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic l);
    logic accepted;
    accepted = 1'b0;
    bus.s_axi_valid = 1'b1;
    bus.s_axi_data  = d;
    bus.s_axi_last  = l;
    for (int i = 0; i < 200 && !accepted; i++) begin
      #4;
      accepted = bus.s_axi_ready;
      @(negedge clk);
    end
    if (!accepted) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout observed=stalled expected=accepted data=%0h", d);
    end
  endtask

  task automatic idle(input int n);
    bus.s_axi_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    bus.s_axi_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expectWord(input logic [63:0] d, input logic tv, input logic [6:0] tt, input logic l);
    exp_q.push_back({d, tv, tt, l});
  endtask

  task automatic compareStream(input string name);
    int n;
    idle(1);
    for (int i = 0; i < 2000 && (got_q.size() - got_base) < exp_q.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n = got_q.size() - got_base;
    checkOutput({name, "_count"}, 73'(n), 73'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_word%0d", name, i), got_q[got_base + i], exp_q[i]);
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic checkErrors(input string name, input int pulses, input logic [15:0] cnt);
    checkOutput({name, "_pulses"}, 73'(err_seen - err_base), 73'(pulses));
    checkOutput({name, "_count"}, 73'(err_count), 73'(cnt));
    err_base = err_seen;
  endtask

  // Reference behaviour of the decoder, fed with every beat of the mixed stream.
  task automatic modelBeat(input logic [63:0] d, input logic l);
    case (m_state)
      0: if (d == ESC_R) begin
           if (l) m_errs++; else m_state = 1;
         end else expectWord(d, 1'b0, 7'h0, l);
      1: begin
           m_state = 0;
           if (d[63:56] == 8'h00) expectWord(ESC_R, 1'b0, 7'h0, l);
           else if (d[63:56] == 8'h01 && !l) begin m_type = d[6:0]; m_state = 2; end
           else m_errs++;
         end
      default: begin
           expectWord(d, 1'b1, m_type, l);
           m_state = 0;
         end
    endcase
  endtask

  task automatic sendModel(input logic [63:0] d, input logic l);
    modelBeat(d, l);
    applyStimulus(d, l);
    if ($urandom_range(0, 2) == 0) idle(1);
  endtask

  function automatic logic [63:0] randWord();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w == ESC_R) w = w ^ 64'h1;
    return w;
  endfunction

  initial begin
    int beats;
    int kind;
    logic l;
    logic [63:0] w;
    $display("[TB] start");
    bus.s_axi_valid = 1'b0;
    bus.s_axi_data  = '0;
    bus.s_axi_last  = 1'b0;
    use_tags   = 1'b0;
    tag_escape = ESC_A;
    rst = 1'b1;
    @(negedge clk);
    doReset();
    #4;
    checkOutput("reset_outputs", {bus.m_axi_valid, bus.m_axi_data, bus.m_axi_tag_valid,
                bus.m_axi_tag_type, bus.m_axi_last}, 73'h0);
    checkOutput("reset_err", {err_pulse, err_count}, 73'h0);
    checkOutput("reset_ready", 73'(bus.s_axi_ready), 73'h1);
    @(negedge clk);

    // T1 transparent mode
    applyStimulus(ESC_A, 1'b0);
    applyStimulus(64'h1, 1'b0);
    applyStimulus(64'h2, 1'b1);
    expectWord(ESC_A, 1'b0, 7'h0, 1'b0);
    expectWord(64'h1, 1'b0, 7'h0, 1'b0);
    expectWord(64'h2, 1'b0, 7'h0, 1'b1);
    compareStream("t1");

    // T2 literal escape
    use_tags = 1'b1;
    applyStimulus(64'h5, 1'b0);
    applyStimulus(ESC_A, 1'b0);
    applyStimulus(64'h0, 1'b0);
    applyStimulus(64'h7, 1'b1);
    expectWord(64'h5, 1'b0, 7'h0, 1'b0);
    expectWord(ESC_A, 1'b0, 7'h0, 1'b0);
    expectWord(64'h7, 1'b0, 7'h0, 1'b1);
    compareStream("t2");
    checkErrors("t2", 0, 16'd0);

    // T3 tag payload
    applyStimulus(ESC_A, 1'b0);
    applyStimulus(64'h0100_0000_0000_002A, 1'b0);
    applyStimulus(64'hDEAD, 1'b1);
    expectWord(64'hDEAD, 1'b1, 7'h2A, 1'b1);
    compareStream("t3");

    // T4 bad header
    applyStimulus(ESC_A, 1'b0);
    applyStimulus(64'h0200_0000_0000_0000, 1'b0);
    applyStimulus(64'h9, 1'b0);
    expectWord(64'h9, 1'b0, 7'h0, 1'b0);
    compareStream("t4");
    checkErrors("t4", 1, 16'd1);

    // T5 escape ending a frame
    applyStimulus(ESC_A, 1'b1);
    applyStimulus(64'h4, 1'b0);
    expectWord(64'h4, 1'b0, 7'h0, 1'b0);
    compareStream("t5");
    checkErrors("t5", 1, 16'd2);

    // Output register holds while downstream stalls
    rdy_fixed = 1'b0;
    @(negedge clk);
    applyStimulus(64'h123, 1'b0);
    bus.s_axi_data = 64'h456;
    bus.s_axi_last = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    checkOutput("hold_state", {bus.m_axi_valid, bus.s_axi_ready, bus.m_axi_data, bus.m_axi_last},
                {1'b1, 1'b0, 64'h123, 1'b0});
    @(negedge clk);
    rdy_fixed = 1'b1;
    applyStimulus(64'h456, 1'b1);
    expectWord(64'h123, 1'b0, 7'h0, 1'b0);
    expectWord(64'h456, 1'b0, 7'h0, 1'b1);
    compareStream("hold");

    // Error counter saturation
    for (int i = 0; i < 65533; i++) applyStimulus(ESC_A, 1'b1);
    idle(2);
    checkErrors("sat_reach", 65533, 16'hFFFF);
    for (int i = 0; i < 5; i++) applyStimulus(ESC_A, 1'b1);
    idle(2);
    checkErrors("sat_hold", 5, 16'hFFFF);

    // T6 mixed stream under random handshakes
    tag_escape = ESC_R;
    doReset();
    err_base = err_seen;
    rdy_rand = 1'b1;
    beats = 0;
    while (beats < 1000) begin
      kind = $urandom_range(0, 5);
      l = ($urandom_range(0, 3) == 0);
      case (kind)
        0: begin sendModel(randWord(), l); beats += 1; end
        1: begin sendModel(ESC_R, 1'b0); sendModel({8'h00, 24'($urandom), $urandom}, l); beats += 2; end
        2: begin
             w = {8'h01, 24'($urandom), $urandom};
             sendModel(ESC_R, 1'b0);
             sendModel(w, 1'b0);
             sendModel(($urandom_range(0, 7) == 0) ? ESC_R : randWord(), l);
             beats += 3;
           end
        3: begin
             sendModel(ESC_R, 1'b0);
             sendModel({8'($urandom_range(2, 255)), 24'($urandom), $urandom}, l);
             beats += 2;
           end
        4: begin sendModel(ESC_R, 1'b1); beats += 1; end
        default: begin sendModel(ESC_R, 1'b0); sendModel({8'h01, 24'($urandom), $urandom}, 1'b1); beats += 2; end
      endcase
    end
    compareStream("t6");
    checkErrors("t6", m_errs, 16'(m_errs));
    rdy_rand = 1'b0;

    // Reset while waiting for a tag payload
    @(negedge clk);
    applyStimulus(ESC_R, 1'b0);
    applyStimulus(64'h0100_0000_0000_0011, 1'b0);
    doReset();
    err_base = err_seen;
    #4;
    checkOutput("midtag_reset", {bus.m_axi_valid, err_count}, 73'h0);
    @(negedge clk);
    applyStimulus(64'h55, 1'b1);
    expectWord(64'h55, 1'b0, 7'h0, 1'b1);
    compareStream("midtag_next");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
